lcd_bus_responder: RTL and testbench

//  Responder end of the controller's control-word / wait_ handshake. Watches the 22-bit

---
 rtl/lcd_bus_responder_if.sv | 17 +
 rtl/lcd_bus_responder.sv | 195 +++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_responder_if.sv
// ----------------------------------------------------------------------------
// lcd_bus_responder_if
//   Control-word / wait_ handshake between the microprogrammed controller and
//   the LCD bus responder.
//   bus_controller : 22-bit control word (controller -> responder)
//   data_in        : 8-bit write data, sampled with the write request
//   wait_          : 1 = responder busy, controller keeps polling
//   Modports: master = controller side, slave = responder side.
// ----------------------------------------------------------------------------
interface lcd_bus_responder_if;
  logic [21:0] bus_controller;
  logic [7:0]  data_in;
  logic        wait_;

  modport master (output bus_controller, output data_in, input wait_);
  modport slave  (input bus_controller, input data_in, output wait_);
endinterface

// File: rtl/lcd_bus_responder.sv
// ----------------------------------------------------------------------------
// lcd_bus_responder
//   Captures an LCD write from the controller's control word, generates
//   HD44780-style E/RS/RW/DB timing and holds wait_ high until the LCD has
//   had time to execute the command.
// Ports:
//   clk    : system clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : handshake interface (bus_controller, data_in in; wait_ out)
//   lcd_e  : LCD enable strobe
//   lcd_rs : LCD register select (0 = command, 1 = data)
//   lcd_rw : LCD read/write, tied to write
//   lcd_db : LCD data bus
// Optional feature (macro LCD_INIT_SEQ_EN): after reset, wait 4*LONG_CYC
//   cycles and then autonomously issue the writes 0x38, 0x0C, 0x01, 0x06
//   (RS=0); bus requests are ignored and wait_ stays high until done.
// ----------------------------------------------------------------------------
module lcd_bus_responder #(
  parameter int LCD_WR_BIT = 21,
  parameter int LCD_RS_BIT = 20,
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 12,
  parameter int HOLD_CYC   = 2,
  parameter int EXEC_CYC   = 50,
  parameter int LONG_CYC   = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lcd_bus_responder_if.slave    bus,
  output logic                  lcd_e,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic [7:0]            lcd_db
);

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_HE = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int MAX_A  = (MAX_SP > MAX_HE) ? MAX_SP : MAX_HE;
  localparam int MAX_B  = (MAX_A > LONG_CYC) ? MAX_A : LONG_CYC;
`ifdef LCD_INIT_SEQ_EN
  // The power-up delay is the longest interval the counter has to time.
  localparam int MAX_CYC = (MAX_B > 4 * LONG_CYC) ? MAX_B : 4 * LONG_CYC;
`else
  localparam int MAX_CYC = MAX_B;
`endif
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  // Counter load values: a state lasting N cycles is entered with N-1 and
  // advances on the edge where the counter reads zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
`ifdef LCD_INIT_SEQ_EN
    , S_POWER
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             long_cmd;

  // Clear (0x01) and return-home (0x02/0x03) commands need the long wait.
  assign long_cmd = (lcd_rs == 1'b0) &&
                    ((lcd_db == 8'h01) || (lcd_db == 8'h02) || (lcd_db == 8'h03));

  assign bus.wait_ = busy;
  assign lcd_rw    = 1'b0;

`ifdef LCD_INIT_SEQ_EN
  logic       init_busy;
  logic [1:0] init_idx;

  function automatic logic [7:0] init_word(input logic [1:0] idx);
    case (idx)
      2'd0:    init_word = 8'h38;
      2'd1:    init_word = 8'h0C;
      2'd2:    init_word = 8'h01;
      default: init_word = 8'h06;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      lcd_e  <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_db <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
      init_busy <= 1'b1;
      init_idx  <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
`ifdef LCD_INIT_SEQ_EN
          if (init_busy) begin
            state <= S_POWER;
            cnt   <= CNT_W'(4 * LONG_CYC - 1);
            busy  <= 1'b1;
          end else
`endif
          if (bus.bus_controller[LCD_WR_BIT]) begin
            lcd_db <= bus.data_in;
            lcd_rs <= bus.bus_controller[LCD_RS_BIT];
            state  <= S_SETUP;
            cnt    <= SETUP_LD;
            busy   <= 1'b1;
          end
        end
`ifdef LCD_INIT_SEQ_EN
        S_POWER: begin
          if (cnt == '0) begin
            lcd_db   <= init_word(2'd0);
            lcd_rs   <= 1'b0;
            init_idx <= 2'd0;
            state    <= S_SETUP;
            cnt      <= SETUP_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_SETUP: begin
          if (cnt == '0) begin
            state <= S_PULSE;
            cnt   <= PULSE_LD;
            lcd_e <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            state <= S_HOLD;
            cnt   <= HOLD_LD;
            lcd_e <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state <= S_EXEC;
            cnt   <= long_cmd ? LONG_LD : EXEC_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
            if (init_busy && (init_idx != 2'd3)) begin
              // Chain straight into the next init write; wait_ stays high.
              init_idx <= init_idx + 2'd1;
              lcd_db   <= init_word(init_idx + 2'd1);
              lcd_rs   <= 1'b0;
              state    <= S_SETUP;
              cnt      <= SETUP_LD;
            end else begin
              init_busy <= 1'b0;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end
`else
            state <= S_IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
          lcd_e <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// ----------------------------------------------------------------------------
// tb_lcd_bus_responder
//   Randomised self-checking bench for lcd_bus_responder. The reference model
//   describes each accepted write as a time window: wait_ is high from the
//   accept edge for SETUP+PULSE+HOLD+EXEC(or LONG) cycles, E is high for
//   PULSE cycles starting SETUP edges after acceptance, and a new request is
//   only accepted on an edge strictly after the window closes.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_bus_responder;
  localparam int S = 2;
  localparam int P = 12;
  localparam int H = 2;
  localparam int X = 50;
  localparam int L = 2000;

  logic       clk;
  logic       rst_n;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db;

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(
    .LCD_WR_BIT(21), .LCD_RS_BIT(20), .SETUP_CYC(S), .PULSE_CYC(P),
    .HOLD_CYC(H), .EXEC_CYC(X), .LONG_CYC(L)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state (edge indices since reset release).
  int         cyc;
  int         m_start;
  int         m_end;
  logic       m_rs;
  logic [7:0] m_db;

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? L : X;
  endfunction

  task automatic model_reset();
    cyc = 0; m_start = -1000; m_end = -1; m_rs = 1'b0; m_db = 8'h00;
  endtask

  // Drive one cycle of stimulus, advance the model, sample 1 ns after the edge.
  task automatic step(input logic req, input logic rs, input logic [7:0] d,
                      output logic ew, output logic ee, output logic [8:0] erd);
    bus.bus_controller = {req, rs, 20'($urandom)};
    bus.data_in        = d;
    @(posedge clk);
    cyc++;
    if (req && cyc > m_end) begin
      m_start = cyc;
      m_rs    = rs;
      m_db    = d;
      m_end   = cyc + S + P + H + exec_len(rs, d);
      $display("txn: accept cyc=%0d rs=%0b db=%02h wait_cycles=%0d", cyc, rs, d, m_end - cyc);
    end
    #1;
    ew  = (cyc >= m_start) && (cyc < m_end);
    ee  = (cyc >= m_start + S) && (cyc < m_start + S + P);
    erd = {m_rs, m_db};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.bus_controller = '0;
    bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.bus_controller = '0;
    bus.data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.wait_, lcd_e, lcd_rs, lcd_rw, lcd_db} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state: got wait=%0b e=%0b rs=%0b rw=%0b db=%02h want all 0",
               bus.wait_, lcd_e, lcd_rs, lcd_rw, lcd_db);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One request (optionally a second one while busy), then run n cycles.
  task automatic run_single(input string name, input logic rs, input logic [7:0] d,
                            input int n, input int ovr_at, input logic [7:0] ovr_d,
                            input int want_wait, input int want_e);
    logic ew, ee, req, r;
    logic [8:0] erd;
    logic [7:0] dd;
    int wcnt, ecnt, efirst;
    wcnt = 0; ecnt = 0; efirst = -1;
    for (int i = 0; i < n; i++) begin
      req = (i == 0) || (i == ovr_at);
      dd  = (i == ovr_at) ? ovr_d : d;
      r   = (i == ovr_at) ? 1'b0 : rs;
      step(req, r, dd, ew, ee, erd);
      checks++;
      if (bus.wait_ !== ew || lcd_e !== ee) begin
        failures++;
        $display("FAIL %s_timing: i=%0d got wait=%0b e=%0b want wait=%0b e=%0b",
                 name, i, bus.wait_, lcd_e, ew, ee);
      end
      checks++;
      if ({lcd_rs, lcd_db} !== erd) begin
        failures++;
        $display("FAIL %s_bus: i=%0d got rs/db=%03h want %03h", name, i, {lcd_rs, lcd_db}, erd);
      end
      if (bus.wait_ === 1'b1) wcnt++;
      if (lcd_e === 1'b1) begin
        ecnt++;
        if (efirst < 0) efirst = i;
      end
    end
    checks++;
    if (wcnt != want_wait) begin
      failures++;
      $display("FAIL %s_wait_len: got %0d want %0d", name, wcnt, want_wait);
    end
    checks++;
    if (ecnt != want_e || efirst != S) begin
      failures++;
      $display("FAIL %s_e_pulse: got len=%0d start=%0d want len=%0d start=%0d",
               name, ecnt, efirst, want_e, S);
    end
  endtask

  task automatic test_data_write();
    run_single("data_write", 1'b1, 8'h41, 70, -1, 8'h00, 66, 12);
  endtask

  task automatic test_busy_overrun();
    do_reset();
    run_single("busy_overrun", 1'b1, 8'h41, 70, 6, 8'h55, 66, 12);
  endtask

  task automatic test_clear();
    run_single("clear", 1'b0, 8'h01, 2020, -1, 8'h00, 2016, 12);
  endtask

  task automatic test_back_to_back();
    logic ew, ee, prev_e;
    logic [8:0] erd;
    int pulses, low_gap;
    pulses = 0; low_gap = 0; prev_e = 1'b0;
    for (int i = 0; i < 140; i++) begin
      step(i <= 67, 1'b1, (i == 0) ? 8'h30 : 8'h31, ew, ee, erd);
      checks++;
      if (bus.wait_ !== ew || lcd_e !== ee || {lcd_rs, lcd_db} !== erd) begin
        failures++;
        $display("FAIL back_to_back: i=%0d got wait=%0b e=%0b rs/db=%03h want %0b %0b %03h",
                 i, bus.wait_, lcd_e, {lcd_rs, lcd_db}, ew, ee, erd);
      end
      if (lcd_e === 1'b1 && prev_e === 1'b0) pulses++;
      prev_e = lcd_e;
      if (i > 0 && i < 100 && bus.wait_ === 1'b0) low_gap++;
    end
    checks++;
    if (pulses != 2 || low_gap != 1) begin
      failures++;
      $display("FAIL back_to_back_shape: got pulses=%0d gap=%0d want 2 and 1", pulses, low_gap);
    end
    checks++;
    if (lcd_db !== 8'h31) begin
      failures++;
      $display("FAIL back_to_back_db: got %02h want 31", lcd_db);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic ew, ee;
    logic [8:0] erd;
    do_reset();
    for (int i = 0; i < 8; i++) step(i == 0, 1'b1, 8'h5A, ew, ee, erd);
    checks++;
    if (lcd_e !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_pulse: got e=%0b want 1", lcd_e);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wait_, lcd_e, lcd_db} !== 10'h000) begin
      failures++;
      $display("FAIL reset_async: got wait=%0b e=%0b db=%02h want 0 0 00", bus.wait_, lcd_e, lcd_db);
    end
    do_reset();
    step(1'b0, 1'b0, 8'h00, ew, ee, erd);
    checks++;
    if ({bus.wait_, lcd_e, lcd_rs, lcd_db} !== {ew, ee, erd}) begin
      failures++;
      $display("FAIL reset_release: got wait=%0b e=%0b rs/db=%03h want idle zeros",
               bus.wait_, lcd_e, {lcd_rs, lcd_db});
    end
  endtask

  task automatic test_random();
    logic ew, ee;
    logic [8:0] erd;
    logic [7:0] d;
    for (int i = 0; i < 2500; i++) begin
      d = 8'($urandom);
      step($urandom_range(0, 7) == 0, 1'($urandom), d, ew, ee, erd);
      checks++;
      if (bus.wait_ !== ew || lcd_e !== ee || {lcd_rs, lcd_db} !== erd) begin
        failures++;
        $display("FAIL random: i=%0d got wait=%0b e=%0b rs/db=%03h want %0b %0b %03h",
                 i, bus.wait_, lcd_e, {lcd_rs, lcd_db}, ew, ee, erd);
      end
    end
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic test_init_seq();
    logic [7:0] seen [$];
    logic prev_e;
    int fall;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.bus_controller = 22'h300000;
    bus.data_in = 8'h77;
    prev_e = 1'b0; fall = -1;
    for (int i = 1; i <= 20000 && fall < 0; i++) begin
      @(posedge clk); #1;
      if (lcd_e === 1'b1 && prev_e === 1'b0) begin
        seen.push_back(lcd_db);
        $display("txn: init write db=%02h rs=%0b", lcd_db, lcd_rs);
      end
      prev_e = lcd_e;
      if (bus.wait_ !== 1'b1) fall = i;
    end
    checks++;
    if (fall != 1 + 4 * L + 4 * (S + P + H) + 3 * X + L) begin
      failures++;
      $display("FAIL init_wait: wait_ fell at edge %0d want %0d", fall, 1 + 4 * L + 4 * (S + P + H) + 3 * X + L);
    end
    checks++;
    if (seen.size() != 4 || seen[0] !== 8'h38 || seen[1] !== 8'h0C || seen[2] !== 8'h01 || seen[3] !== 8'h06) begin
      failures++;
      $display("FAIL init_seq: got %0d pulses first=%02h want 38 0C 01 06", seen.size(),
               (seen.size() > 0) ? seen[0] : 8'h00);
    end
    bus.bus_controller = '0;
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.bus_controller = '0;
    bus.data_in = 8'h00;
    model_reset();
    test_reset();
`ifdef LCD_INIT_SEQ_EN
    test_init_seq();
`else
    test_data_write();
    test_busy_overrun();
    test_clear();
    test_back_to_back();
    test_reset_mid_pulse();
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
